// File: rtl/hex_display_sequencer.sv
// Board-level display controller: switch value on HEX1/HEX0, one-shot scrolling
// date message on key[1], LED inversion toggled by key[0].
module hex_display_sequencer #(
    parameter int          TICK_DIV   = 25000000,
    parameter int          DEB_CYCLES = 500000,
    parameter logic [31:0] MSG        = 32'h0514_2001
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] switch,
    input  logic [1:0] key,
    output logic [9:0] leds,
    output logic [7:0] hex0,
    output logic [7:0] hex1,
    output logic [7:0] hex2,
    output logic [7:0] hex3,
    output logic [7:0] hex4,
    output logic [7:0] hex5,
    output logic       busy
);

    // state  | meaning
    // SHOW   | switch value on hex1/hex0, hex5..hex2 blank
    // SCROLL | message window slides one character per TICK_DIV cycles
    typedef enum logic {SHOW, SCROLL} state_t;

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [3:0]        LAST_STEP = 4'd14;

    function automatic logic [7:0] seg(input logic [3:0] n);
        logic [7:0] s;
        s = 8'hFF;
        case (n)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  4'hF: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Stream position idx: 0..5 blank, 6..13 message nibbles (MSB first), 14..19 blank.
    function automatic logic [7:0] scrollChar(input logic [4:0] idx);
        logic [31:0] shifted;
        logic [2:0]  k;
        k       = 3'(idx - 5'd6);
        shifted = MSG << {k, 2'b00};
        if (idx >= 5'd6 && idx <= 5'd13) return seg(shifted[31:28]);
        return 8'hFF;
    endfunction

    logic [1:0]       keyMeta, keySync, keyLevel, keyPress;
    logic [DEB_W-1:0] debCnt [2];
    logic [7:0]       switchReg;

    state_t            state, stateNext;
    logic [3:0]        step, stepNext;
    logic [TICK_W-1:0] tickCnt, tickNext;
    logic              inv, invNext;

    logic [7:0] hexNext [6];
    logic [9:0] ledsNext;
    logic       busyNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keyMeta   <= '0;
            keySync   <= '0;
            switchReg <= '0;
        end else begin
            keyMeta   <= key;
            keySync   <= keyMeta;
            switchReg <= switch;
        end
    end

    // Debounce: level follows keySync only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keyLevel <= '0;
            keyPress <= '0;
            for (int k = 0; k < 2; k++) debCnt[k] <= DEB_LOAD;
        end else begin
            for (int k = 0; k < 2; k++) begin
                keyPress[k] <= 1'b0;
                if (keySync[k] == keyLevel[k]) begin
                    debCnt[k] <= DEB_LOAD;
                end else if (debCnt[k] == '0) begin
                    keyLevel[k] <= keySync[k];
                    keyPress[k] <= keySync[k];
                    debCnt[k]   <= DEB_LOAD;
                end else begin
                    debCnt[k] <= debCnt[k] - DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SHOW;
            step    <= '0;
            tickCnt <= '0;
            inv     <= 1'b0;
        end else begin
            state   <= stateNext;
            step    <= stepNext;
            tickCnt <= tickNext;
            inv     <= invNext;
        end
    end

    always_comb begin
        stateNext = state;
        stepNext  = step;
        tickNext  = tickCnt;
        invNext   = inv ^ keyPress[0];
        case (state)
            SHOW: begin
                if (keyPress[1]) begin
                    stateNext = SCROLL;
                    stepNext  = '0;
                    tickNext  = '0;
                end
            end
            SCROLL: begin
                if (keyPress[1]) begin
                    stepNext = '0;
                    tickNext = '0;
                end else if (tickCnt == TICK_LAST) begin
                    tickNext = '0;
                    if (step == LAST_STEP) begin
                        stateNext = SHOW;
                        stepNext  = '0;
                    end else begin
                        stepNext = step + 4'd1;
                    end
                end else begin
                    tickNext = tickCnt + TICK_W'(1);
                end
            end
        endcase
    end

    // Outputs are derived from the next-state values so the registered pins line up with the FSM.
    always_comb begin
        busyNext = (stateNext == SCROLL);
        ledsNext = {busyNext, invNext, switchReg ^ {8{invNext}}};
        for (int i = 0; i < 6; i++) hexNext[i] = 8'hFF;
        if (stateNext == SHOW) begin
            hexNext[0] = seg(switchReg[3:0]);
            hexNext[1] = seg(switchReg[7:4]);
        end else begin
            for (int i = 0; i < 6; i++) hexNext[i] = scrollChar({1'b0, stepNext} + 5'(5 - i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex0 <= 8'hFF;
            hex1 <= 8'hFF;
            hex2 <= 8'hFF;
            hex3 <= 8'hFF;
            hex4 <= 8'hFF;
            hex5 <= 8'hFF;
            leds <= '0;
            busy <= 1'b0;
        end else begin
            hex0 <= hexNext[0];
            hex1 <= hexNext[1];
            hex2 <= hexNext[2];
            hex3 <= hexNext[3];
            hex4 <= hexNext[4];
            hex5 <= hexNext[5];
            leds <= ledsNext;
            busy <= busyNext;
        end
    end

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Scoreboard bench for hex_display_sequencer: stimulus queues expected pin snapshots
// tagged with a cycle number; a negedge monitor compares them when that cycle arrives.
module tb_hex_display_sequencer;

    localparam logic [47:0] FF6    = {6{8'hFF}};
    localparam logic [47:0] HEX_A5 = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'h92};
    localparam logic [47:0] HEX_00 = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hC0};
    localparam logic [47:0] STEP1  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0};
    localparam logic [47:0] STEP5  = {8'hFF, 8'hC0, 8'h92, 8'hF9, 8'h99, 8'hA4};
    localparam logic [47:0] STEP7  = {8'h92, 8'hF9, 8'h99, 8'hA4, 8'hC0, 8'hC0};
    localparam logic [47:0] STEP8  = {8'hF9, 8'h99, 8'hA4, 8'hC0, 8'hC0, 8'hF9};

    logic       clk;
    logic       reset;
    logic [7:0] switch;
    logic [1:0] key;
    logic [9:0] leds;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic       busy;

    typedef struct {
        int          cyc;
        string       name;
        logic [47:0] hex;
        logic [9:0]  leds;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    hex_display_sequencer #(.TICK_DIV(4), .DEB_CYCLES(3), .MSG(32'h0514_2001)) dut (
        .clk(clk), .reset(reset), .switch(switch), .key(key), .leds(leds),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectAt(input int delay, input string name, input logic [47:0] hex,
                            input logic [9:0] ledsExp, input logic busyExp);
        exp_t e;
        e.cyc  = cyc + delay;
        e.name = name;
        e.hex  = hex;
        e.leds = ledsExp;
        e.busy = busyExp;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        logic [47:0] hexAct;
        hexAct = {hex5, hex4, hex3, hex2, hex1, hex0};
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", q[i].name, q[i].cyc, cyc);
                q.delete(i);
            end else if (q[i].cyc == cyc) begin
                compared++;
                if (hexAct !== q[i].hex || leds !== q[i].leds || busy !== q[i].busy) begin
                    mismatched++;
                    $display("FAIL %s @cyc %0d: got hex=%h leds=%h busy=%b, want hex=%h leds=%h busy=%b",
                             q[i].name, cyc, hexAct, leds, busy, q[i].hex, q[i].leds, q[i].busy);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        switch = 8'h00;
        key    = 2'b00;
        cycles(3);
        reset  = 1'b0;
        switch = 8'hA5;
        expectAt(0, "reset_state", FF6, 10'h000, 1'b0);
        expectAt(1, "switch_latency", HEX_00, 10'h000, 1'b0);
        expectAt(2, "switch_a5", HEX_A5, 10'h0A5, 1'b0);
        cycles(4);

        key = 2'b01;
        expectAt(8, "glitch_no_toggle", HEX_A5, 10'h0A5, 1'b0);
        cycles(2);
        key = 2'b00;
        cycles(10);

        key = 2'b01;
        expectAt(5, "inv_before_debounce", HEX_A5, 10'h0A5, 1'b0);
        expectAt(6, "inv_toggle", HEX_A5, 10'h15A, 1'b0);
        expectAt(20, "inv_single_toggle", HEX_A5, 10'h15A, 1'b0);
        cycles(10);
        key = 2'b00;
        cycles(15);

        key = 2'b10;
        expectAt(5, "scroll_pre", HEX_A5, 10'h15A, 1'b0);
        expectAt(6, "scroll_step0", FF6, 10'h35A, 1'b1);
        expectAt(10, "scroll_step1", STEP1, 10'h35A, 1'b1);
        expectAt(26, "scroll_step5", STEP5, 10'h35A, 1'b1);
        expectAt(38, "scroll_step8", STEP8, 10'h35A, 1'b1);
        expectAt(65, "scroll_step14_last", FF6, 10'h35A, 1'b1);
        expectAt(66, "scroll_done", HEX_A5, 10'h15A, 1'b0);
        cycles(6);
        key = 2'b00;
        cycles(70);

        key = 2'b10;
        expectAt(27, "restart_pre_step5", STEP5, 10'h35A, 1'b1);
        expectAt(28, "restart_blank", FF6, 10'h35A, 1'b1);
        expectAt(32, "restart_step1", STEP1, 10'h35A, 1'b1);
        expectAt(87, "restart_last", FF6, 10'h35A, 1'b1);
        expectAt(88, "restart_done", HEX_A5, 10'h15A, 1'b0);
        cycles(6);
        key = 2'b00;
        cycles(16);
        key = 2'b10;
        cycles(6);
        key = 2'b00;
        cycles(70);

        key = 2'b01;
        expectAt(6, "inv_clear", HEX_A5, 10'h0A5, 1'b0);
        cycles(6);
        key = 2'b00;
        cycles(10);

        key = 2'b11;
        expectAt(5, "both_pre", HEX_A5, 10'h0A5, 1'b0);
        expectAt(6, "both_press", FF6, 10'h35A, 1'b1);
        expectAt(34, "scroll_step7", STEP7, 10'h35A, 1'b1);
        cycles(6);
        key = 2'b00;
        cycles(29);
        #1;
        reset = 1'b1;
        expectAt(0, "async_reset", FF6, 10'h000, 1'b0);
        cycles(2);
        reset = 1'b0;
        expectAt(1, "post_reset_sw_cleared", HEX_00, 10'h000, 1'b0);
        expectAt(2, "post_reset_sw", HEX_A5, 10'h0A5, 1'b0);
        cycles(4);

        if (q.size() != 0) begin
            foreach (q[i]) $display("FAIL %s: expectation for cycle %0d never checked", q[i].name, q[i].cyc);
            compared   += q.size();
            mismatched += q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
